// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receive front end.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    // Width able to hold the values 0..size inclusive (bit counter saturates at size).
    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchronizer bank for asynchronous single-bit inputs.
module sync_2ff #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d_i,
    output logic [width-1:0] q_o
);

    logic [width-1:0] meta_q;
    logic [width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S deserializer: recovers stereo sample pairs from the codec bit stream
// and strobes o_valid once per complete left+right frame while locked.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int size           = 16,
    parameter int timeout_cycles = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sclk,
    input  logic            i_lrck,
    input  logic            i_sdata,
    output logic [size-1:0] o_left,
    output logic [size-1:0] o_right,
    output logic            o_valid,
    output logic            o_err,
    output logic            o_locked
);

    localparam int CW = cnt_w(size);
    localparam int IW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] SIZE_C   = CW'(size);
    localparam logic [CW-1:0] MSB_POS  = CW'(size - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(timeout_cycles);

    logic [2:0] sync_s;
    logic       sclk_s;
    logic       lrck_s;
    logic       sdata_s;

    sync_2ff #(.width(3)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   ({i_sclk, i_lrck, i_sdata}),
        .q_o   (sync_s)
    );

    assign sclk_s  = sync_s[2];
    assign lrck_s  = sync_s[1];
    assign sdata_s = sync_s[0];

    i2s_state_t      state_q, state_d;
    logic            sclk_prev_q;
    logic            lrck_prev_q, lrck_prev_d;
    logic            chan_q, chan_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [size-1:0] shreg_q, shreg_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [size-1:0] left_hold_q, left_hold_d;
    logic            left_short_q, left_short_d;
    logic [size-1:0] left_out_q, left_out_d;
    logic [size-1:0] right_out_q, right_out_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            sclk_rise;
    logic            chan_new;
    logic            boundary;
    logic            slot_short;
    logic            timeout;
    logic [CW-1:0]   bit_pos;

    // A bit belongs to the channel LRCK showed on the previous SCLK rise,
    // which gives the one-bit I2S delay; a slot starts when that channel changes.
    always_comb begin
        sclk_rise  = sclk_s & ~sclk_prev_q;
        chan_new   = lrck_prev_q;
        boundary   = sclk_rise && (chan_new != chan_q);
        slot_short = (bit_cnt_q < SIZE_C);
        timeout    = (idle_q >= IDLE_MAX);
        bit_pos    = MSB_POS - bit_cnt_q;
    end

    always_comb begin
        lrck_prev_d = lrck_prev_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        idle_d      = idle_q;

        if (sclk_rise) begin
            idle_d = '0;
        end else if (!timeout) begin
            idle_d = idle_q + 1'b1;
        end

        if (sclk_rise) begin
            lrck_prev_d = lrck_s;
            chan_d      = chan_new;
            if (boundary) begin
                shreg_d   = {sdata_s, {(size-1){1'b0}}};
                bit_cnt_d = CW'(1);
            end else if (slot_short) begin
                shreg_d   = shreg_q | ({{(size-1){1'b0}}, sdata_s} << bit_pos);
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM; a timeout forces SYNC even on a cycle that is also a boundary.
    always_comb begin
        state_d      = state_q;
        left_hold_d  = left_hold_q;
        left_short_d = left_short_q;
        left_out_d   = left_out_q;
        right_out_d  = right_out_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        if (timeout) begin
            state_d = SYNC;
        end else if (boundary) begin
            case (state_q)
                SYNC: begin
                    if (chan_q && !chan_new) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (!chan_q && chan_new) begin
                        left_hold_d  = shreg_q;
                        left_short_d = slot_short;
                        state_d      = RIGHT;
                    end
                end
                RIGHT: begin
                    if (chan_q && !chan_new) begin
                        left_out_d  = left_hold_q;
                        right_out_d = shreg_q;
                        valid_d     = 1'b1;
                        err_d       = left_short_q | slot_short;
                        state_d     = LEFT;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SYNC;
            sclk_prev_q  <= 1'b0;
            lrck_prev_q  <= 1'b0;
            chan_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            idle_q       <= '0;
            left_hold_q  <= '0;
            left_short_q <= 1'b0;
            left_out_q   <= '0;
            right_out_q  <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_prev_q  <= sclk_s;
            lrck_prev_q  <= lrck_prev_d;
            chan_q       <= chan_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            idle_q       <= idle_d;
            left_hold_q  <= left_hold_d;
            left_short_q <= left_short_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign o_left   = left_out_q;
    assign o_right  = right_out_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_locked = (state_q != SYNC);

endmodule
